mem_access_stage: RTL

Pipeline MEM stage placed directly downstream of the EX/MEM pipeline register. It consumes that register's outputs and runs the load/store on an external data-memory bus using a req/ack handshake. It stalls the front of the pipeline while an access is outstanding, aborts accesses that hang, and produces the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_access_stage_if.sv | 39 +++
 rtl/mem_access_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory bus between the MEM pipeline stage (master) and the data memory
// (slave), using a req/ack handshake.
//
// Signals:
//   mem_req    master->slave  request, held high until ack or abort
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  32-bit byte address
//   mem_wdata  master->slave  32-bit store data
//   mem_ack    slave->master  completion, sampled on posedge while mem_req=1
//   mem_rdata  slave->master  read data, valid in the cycle mem_ack=1
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Pipeline MEM stage fed by the EX/MEM register. Non-memory instructions pass
// straight into the MEM/WB register. Loads/stores are issued on the data-memory
// bus with a req/ack handshake; the front of the pipeline is stalled while an
// access is outstanding, and an access with no ack after MAX_WAIT ACCESS cycles
// is aborted (instruction squashed, one-cycle bus_err pulse).
//
// Parameters:
//   MAX_WAIT   ACCESS cycles without ack before abort (1..255)
//
// Optional feature (compile-time macro):
//   MEM_ALIGN_CHECK_EN  when defined, a memory op whose address has
//                       aluresult2[1:0] != 0 is not issued; it is squashed
//                       and bus_err pulses on the following cycle.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   aluresult2, rtresult2, desreg2    EX/MEM data fields
//   MemRead2, MemWrite2,
//   MemtoReg2, Regwrite2              EX/MEM control bits
//   bus                               data-memory bus (master modport)
//   stall                             combinational upstream hold request
//   bus_err                           registered one-cycle abort pulse
//   wb_readdata, wb_aluresult,
//   wb_desreg, wb_MemtoReg,
//   wb_Regwrite                       MEM/WB pipeline register
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                aluresult2,
  input  logic [31:0]                rtresult2,
  input  logic [4:0]                 desreg2,
  input  logic                       MemRead2,
  input  logic                       MemWrite2,
  input  logic                       MemtoReg2,
  input  logic                       Regwrite2,
  mem_access_stage_if.master         bus,
  output logic                       stall,
  output logic                       bus_err,
  output logic [31:0]                wb_readdata,
  output logic [31:0]                wb_aluresult,
  output logic [4:0]                 wb_desreg,
  output logic                       wb_MemtoReg,
  output logic                       wb_Regwrite
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // wait_cnt value in the last ACCESS cycle before the access is abandoned
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        bus_err_r;
  logic [4:0]  lat_desreg_r;
  logic        lat_memtoreg_r;
  logic        lat_regwrite_r;

  logic [31:0] wb_readdata_r;
  logic [31:0] wb_aluresult_r;
  logic [4:0]  wb_desreg_r;
  logic        wb_memtoreg_r;
  logic        wb_regwrite_r;

  logic        mem_op_s;
  logic        misalign_s;
  logic        issue_s;
  logic        abort_s;
  logic        stall_s;
  logic [31:0] wb_readdata_s;
  logic [31:0] wb_aluresult_s;
  logic [4:0]  wb_desreg_s;
  logic        wb_memtoreg_s;
  logic        wb_regwrite_s;

  assign mem_op_s = MemRead2 | MemWrite2;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (aluresult2[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  assign issue_s = mem_op_s & ~misalign_s;

  // Ack has priority: abort only when the last wait cycle passes without ack.
  assign abort_s = ~bus.mem_ack & (wait_cnt_r == LAST_WAIT);

  // Upstream hold request; forced low while reset is asserted.
  always_comb begin
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:   stall_s = issue_s;
        ST_ACCESS: stall_s = ~bus.mem_ack & ~abort_s;
        default:   stall_s = 1'b0;
      endcase
    end
  end

  // Next MEM/WB contents; anything not explicitly loaded is a bubble (all zero).
  always_comb begin
    wb_readdata_s  = 32'd0;
    wb_aluresult_s = 32'd0;
    wb_desreg_s    = 5'd0;
    wb_memtoreg_s  = 1'b0;
    wb_regwrite_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!mem_op_s) begin
          wb_aluresult_s = aluresult2;
          wb_desreg_s    = desreg2;
          wb_memtoreg_s  = MemtoReg2;
          wb_regwrite_s  = Regwrite2;
        end else begin
          wb_memtoreg_s  = 1'b0;
          wb_regwrite_s  = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ack) begin
          // mem_addr_r holds the latched ALU result of the memory instruction
          wb_aluresult_s = mem_addr_r;
          wb_desreg_s    = lat_desreg_r;
          wb_memtoreg_s  = lat_memtoreg_r;
          wb_regwrite_s  = lat_regwrite_r;
          wb_readdata_s  = mem_we_r ? 32'd0 : bus.mem_rdata;
        end else begin
          wb_memtoreg_s  = 1'b0;
          wb_regwrite_s  = 1'b0;
        end
      end
      default: begin
        wb_memtoreg_s  = 1'b0;
        wb_regwrite_s  = 1'b0;
      end
    endcase
  end

  // Access FSM: bus request, latched instruction fields, wait counter, abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      wait_cnt_r     <= 8'd0;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= 32'd0;
      bus_err_r      <= 1'b0;
      lat_desreg_r   <= 5'd0;
      lat_memtoreg_r <= 1'b0;
      lat_regwrite_r <= 1'b0;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            state_r        <= ST_ACCESS;
            wait_cnt_r     <= 8'd0;
            mem_req_r      <= 1'b1;
            // read+write together is treated as a write
            mem_we_r       <= MemWrite2;
            mem_addr_r     <= aluresult2;
            mem_wdata_r    <= rtresult2;
            lat_desreg_r   <= desreg2;
            lat_memtoreg_r <= MemtoReg2;
            lat_regwrite_r <= Regwrite2;
          end else if (mem_op_s) begin
            // only reachable for a misaligned op when alignment checking is on
            bus_err_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (abort_s) begin
            mem_req_r <= 1'b0;
            bus_err_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_readdata_r  <= 32'd0;
      wb_aluresult_r <= 32'd0;
      wb_desreg_r    <= 5'd0;
      wb_memtoreg_r  <= 1'b0;
      wb_regwrite_r  <= 1'b0;
    end else begin
      wb_readdata_r  <= wb_readdata_s;
      wb_aluresult_r <= wb_aluresult_s;
      wb_desreg_r    <= wb_desreg_s;
      wb_memtoreg_r  <= wb_memtoreg_s;
      wb_regwrite_r  <= wb_regwrite_s;
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  assign stall         = stall_s;
  assign bus_err       = bus_err_r;
  assign wb_readdata   = wb_readdata_r;
  assign wb_aluresult  = wb_aluresult_r;
  assign wb_desreg     = wb_desreg_r;
  assign wb_MemtoReg   = wb_memtoreg_r;
  assign wb_Regwrite   = wb_regwrite_r;

endmodule
